rf_regs: RTL and testbench

Register file sitting directly downstream of the SPI command interface in the function-generator datapath. It consumes the interface's single-cycle read/write strobes, address and write data, and returns read data. It holds double-buffered generator settings (control, frequency tuning word, amplitude, offset) and drives the active copies to the DDS core. Shadow-to-active transfer happens on an explicit commit, either immediately or aligned to the DDS phase wrap, so waveform changes are glitch-free.

---
 rtl/rf_regs_if.sv | 23 ++
 rtl/rf_regs.sv | 164 ++++++++++++++++
 tb/tb_rf_regs.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rf_regs_if.sv
// Register-bus between the SPI command front end and rf_regs.
// The bus carries single-cycle read/write strobes, the address, write data, and registered read data.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 8
`endif
`ifndef RF_DATA_WIDTH
`define RF_DATA_WIDTH 16
`endif

interface rf_regs_if #(
    parameter int ADDR_W = `RF_ADDR_WIDTH,
    parameter int DATA_W = `RF_DATA_WIDTH
);
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;

    modport master (output re, we, addr, wdata, input rdata, rd_valid);
    modport slave  (input re, we, addr, wdata, output rdata, rd_valid);
endinterface

// File: rtl/rf_regs.sv
// Double-buffered function-generator settings.
// Shadow registers are loaded into the active set on commit, either immediately or on a DDS phase wrap.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 8
`endif
`ifndef RF_DATA_WIDTH
`define RF_DATA_WIDTH 16
`endif

module rf_regs #(
    parameter int ADDR_W = `RF_ADDR_WIDTH,
    parameter int DATA_W = `RF_DATA_WIDTH
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_i,
    rf_regs_if.slave            int_bus,
    input  logic                phase_wrap_i,
    output logic                gen_en_o,
    output logic [1:0]          wave_sel_o,
    output logic [2*DATA_W-1:0] ftw_o,
    output logic [DATA_W-1:0]   ampl_o,
    output logic [DATA_W-1:0]   offs_o,
    output logic                update_o
);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_FREQ_L = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_FREQ_H = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_AMPL   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_OFFS   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(7);
    localparam logic [DATA_W-1:0] ID_VAL   = DATA_W'(16'hAF10);
    localparam logic [DATA_W-1:0] AMPL_RST = {1'b0, {(DATA_W-1){1'b1}}};

    logic [3:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] freq_l_q, freq_l_d, freq_h_q, freq_h_d;
    logic [DATA_W-1:0] ampl_q, ampl_d, offs_q, offs_d;
    logic [2:0]        act_ctrl_q, act_ctrl_d;
    logic [2*DATA_W-1:0] act_ftw_q, act_ftw_d;
    logic [DATA_W-1:0] act_ampl_q, act_ampl_d, act_offs_q, act_offs_d;
    logic              pending_q, pending_d, err_q, err_d;
    logic              update_q, update_d, rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              load_s, addr_hi_s, err_set_s, err_clr_s;

    // Register decode, commit/load control, sticky error and read mux.
    always_comb begin
        ctrl_d     = ctrl_q;
        freq_l_d   = freq_l_q;
        freq_h_d   = freq_h_q;
        ampl_d     = ampl_q;
        offs_d     = offs_q;
        act_ctrl_d = act_ctrl_q;
        act_ftw_d  = act_ftw_q;
        act_ampl_d = act_ampl_q;
        act_offs_d = act_offs_q;
        pending_d  = pending_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        rd_valid_d = int_bus.re;

        // SYNC comes from the shadow CTRL, so rewriting CTRL while pending changes the mode.
        load_s    = pending_q & (~ctrl_q[3] | phase_wrap_i);
        update_d  = load_s;
        addr_hi_s = (int_bus.addr > A_ID);
        err_set_s = (int_bus.we & ((int_bus.addr == A_STATUS) | (int_bus.addr == A_ID) | addr_hi_s))
                  | (int_bus.re & addr_hi_s);
        err_clr_s = int_bus.re & (int_bus.addr == A_STATUS);

        if (load_s) begin
            act_ctrl_d = ctrl_q[2:0];
            act_ftw_d  = {freq_h_q, freq_l_q};
            act_ampl_d = ampl_q;
            act_offs_d = offs_q;
            pending_d  = 1'b0;
        end else if (int_bus.we && (int_bus.addr == A_COMMIT) && int_bus.wdata[0]) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        if (int_bus.we) begin
            case (int_bus.addr)
                A_CTRL:   ctrl_d   = int_bus.wdata[3:0];
                A_FREQ_L: freq_l_d = int_bus.wdata;
                A_FREQ_H: freq_h_d = int_bus.wdata;
                A_AMPL:   ampl_d   = int_bus.wdata;
                A_OFFS:   offs_d   = int_bus.wdata;
                default:  ctrl_d   = ctrl_q;
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end

        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        // Read mux uses pre-write state, so a simultaneous read returns the old value.
        if (int_bus.re) begin
            case (int_bus.addr)
                A_CTRL:   rdata_d = {{(DATA_W-4){1'b0}}, ctrl_q};
                A_FREQ_L: rdata_d = freq_l_q;
                A_FREQ_H: rdata_d = freq_h_q;
                A_AMPL:   rdata_d = ampl_q;
                A_OFFS:   rdata_d = offs_q;
                A_STATUS: rdata_d = {{(DATA_W-3){1'b0}}, err_q, act_ctrl_q[0], pending_q};
                A_ID:     rdata_d = ID_VAL;
                default:  rdata_d = {DATA_W{1'b0}};
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            ctrl_q     <= 4'd0;
            freq_l_q   <= {DATA_W{1'b0}};
            freq_h_q   <= {DATA_W{1'b0}};
            ampl_q     <= AMPL_RST;
            offs_q     <= {DATA_W{1'b0}};
            act_ctrl_q <= 3'd0;
            act_ftw_q  <= {(2*DATA_W){1'b0}};
            act_ampl_q <= AMPL_RST;
            act_offs_q <= {DATA_W{1'b0}};
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            update_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rdata_q    <= {DATA_W{1'b0}};
        end else begin
            ctrl_q     <= ctrl_d;
            freq_l_q   <= freq_l_d;
            freq_h_q   <= freq_h_d;
            ampl_q     <= ampl_d;
            offs_q     <= offs_d;
            act_ctrl_q <= act_ctrl_d;
            act_ftw_q  <= act_ftw_d;
            act_ampl_q <= act_ampl_d;
            act_offs_q <= act_offs_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
            update_q   <= update_d;
            rd_valid_q <= rd_valid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign int_bus.rdata    = rdata_q;
    assign int_bus.rd_valid = rd_valid_q;
    assign gen_en_o         = act_ctrl_q[0];
    assign wave_sel_o       = act_ctrl_q[2:1];
    assign ftw_o            = act_ftw_q;
    assign ampl_o           = act_ampl_q;
    assign offs_o           = act_offs_q;
    assign update_o         = update_q;
endmodule

// File: tb/tb_rf_regs.sv
// Self-checking bench for rf_regs: directed scenarios plus random traffic against a register-map model.
module tb_rf_regs;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wrap = 1'b0;
    logic          gen_en, update;
    logic [1:0]    wave_sel;
    logic [31:0]   ftw;
    logic [15:0]   ampl, offs;
    int            n_tests = 0;
    int            n_fail  = 0;

    // Behavioural model: map contents, active set, pending/error flags, read port
    logic [15:0] m_sh [0:4];
    logic [15:0] m_act_ctrl, m_act_fl, m_act_fh, m_act_ampl, m_act_offs;
    logic        m_pend, m_err, m_rdv, m_upd;
    logic [15:0] m_rdata;

    rf_regs_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rf_regs #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .sys_clk_i(clk), .sys_rst_i(rst), .int_bus(bus), .phase_wrap_i(wrap),
        .gen_en_o(gen_en), .wave_sel_o(wave_sel), .ftw_o(ftw), .ampl_o(ampl),
        .offs_o(offs), .update_o(update)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 5; i++) m_sh[i] = 16'h0000;
        m_sh[3]    = 16'h7FFF;
        m_act_ctrl = 16'h0000; m_act_fl = 16'h0000; m_act_fh = 16'h0000;
        m_act_ampl = 16'h7FFF; m_act_offs = 16'h0000;
        m_pend = 1'b0; m_err = 1'b0; m_rdv = 1'b0; m_upd = 1'b0; m_rdata = 16'h0000;
    endtask

    task automatic m_step(input logic re, input logic we, input logic [7:0] a,
                          input logic [15:0] d, input logic w);
        logic        ld;
        logic [15:0] rv;
        ld = m_pend && (!m_sh[0][3] || w);
        rv = 16'h0000;
        if (re && a < 8'd5) rv = m_sh[a];
        if (re && a == 8'd6) rv = 16'(m_err) * 16'd4 + 16'(m_act_ctrl[0]) * 16'd2 + 16'(m_pend);
        if (re && a == 8'd7) rv = 16'hAF10;
        if (ld) begin
            m_act_ctrl = m_sh[0] & 16'h0007;
            m_act_fl = m_sh[1]; m_act_fh = m_sh[2];
            m_act_ampl = m_sh[3]; m_act_offs = m_sh[4];
            m_pend = 1'b0;
        end else if (we && a == 8'd5 && d[0]) begin
            m_pend = 1'b1;
        end
        if (we && a < 8'd5) m_sh[a] = (a == 8'd0) ? (d & 16'h000F) : d;
        if ((we && a >= 8'd6) || (re && a >= 8'd8)) m_err = 1'b1;
        else if (re && a == 8'd6) m_err = 1'b0;
        m_upd = ld;
        m_rdv = re;
        if (re) m_rdata = rv;
    endtask

    task automatic compare_all();
        check("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
        check("rdata", 32'(bus.rdata), 32'(m_rdata));
        check("update", 32'(update), 32'(m_upd));
        check("gen_en", 32'(gen_en), 32'(m_act_ctrl[0]));
        check("wave_sel", 32'(wave_sel), 32'(m_act_ctrl[2:1]));
        check("ftw", ftw, {m_act_fh, m_act_fl});
        check("ampl", 32'(ampl), 32'(m_act_ampl));
        check("offs", 32'(offs), 32'(m_act_offs));
    endtask

    // One bus cycle: drive at negedge, model the edge, compare at the next negedge.
    task automatic cyc(input logic re, input logic we, input logic [7:0] a,
                       input logic [15:0] d, input logic w);
        bus.re = re; bus.we = we; bus.addr = a; bus.wdata = d; wrap = w;
        @(posedge clk);
        m_step(re, we, a, d, w);
        @(negedge clk);
        bus.re = 1'b0; bus.we = 1'b0; wrap = 1'b0;
        compare_all();
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        cyc(1'b1, 1'b0, a, 16'h0000, 1'b0);
    endtask

    task automatic idle(input logic w);
        cyc(1'b0, 1'b0, 8'h00, 16'h0000, w);
    endtask

    initial begin
        bus.re = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.wdata = 16'h0000;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        compare_all();
        check("rst_ampl", 32'(ampl), 32'h0000_7FFF);

        rd(8'h07);
        check("id", 32'(bus.rdata), 32'h0000_AF10);
        idle(1'b0);
        check("id_valid_drop", 32'(bus.rd_valid), 32'h0);

        wr(8'h01, 16'h1234); wr(8'h02, 16'h0001); wr(8'h00, 16'h0003);
        check("ftw_before_commit", ftw, 32'h0);
        wr(8'h05, 16'h0001);
        idle(1'b0);
        check("ftw_after_commit", ftw, 32'h0001_1234);
        check("upd_pulse", 32'(update), 32'h1);
        check("wave_after_commit", 32'(wave_sel), 32'h1);
        idle(1'b0);
        check("upd_single", 32'(update), 32'h0);

        wr(8'h00, 16'h0009); wr(8'h05, 16'h0001);
        repeat (50) idle(1'b0);
        rd(8'h06);
        check("status_pending", 32'(bus.rdata), 32'h0000_0003);
        idle(1'b1);
        check("sync_load", 32'(update), 32'h1);
        rd(8'h06);
        check("status_after_load", 32'(bus.rdata), 32'h0000_0002);

        cyc(1'b0, 1'b1, 8'h05, 16'h0001, 1'b1);
        idle(1'b0);
        check("coincident_wrap_ignored", 32'(update), 32'h0);
        idle(1'b1);
        check("next_wrap_loads", 32'(update), 32'h1);

        wr(8'h07, 16'h5555);
        rd(8'h06);
        check("err_set", 32'(bus.rdata[2]), 32'h1);
        rd(8'h06);
        check("err_cleared", 32'(bus.rdata[2]), 32'h0);

        wr(8'h03, 16'h7FFF);
        cyc(1'b1, 1'b1, 8'h03, 16'h0100, 1'b0);
        check("rw_old", 32'(bus.rdata), 32'h0000_7FFF);
        rd(8'h03);
        check("rw_new", 32'(bus.rdata), 32'h0000_0100);

        wr(8'h01, 16'hBEEF); wr(8'h05, 16'h0001);
        rst = 1'b1;
        #1;
        m_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);
        check("no_load_after_rst", 32'(update), 32'h0);
        rd(8'h06);
        check("pending_cleared", 32'(bus.rdata[0]), 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [7:0]  a;
            logic [15:0] d;
            a = 8'($urandom_range(0, 10));
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 8'h05;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
                ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
